// File: rtl/inv_sub_bytes_seq.sv
// AES InvSubBytes engine: takes one 128-bit state, substitutes LANES bytes per clock
// through the inverse S-box, then presents the result until the consumer accepts it.
module inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int C  = 16 / LANES;
    localparam int CW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_byte(input logic [7:0] x);
        return INV_SBOX[x];
    endfunction

    state_t                         state_r, state_nx_s;
    logic [CW-1:0]                  cnt_r, cnt_nx_s;
    // work is viewed as C chunks of LANES bytes; chunk 0 holds the lowest bytes
    logic [C-1:0][LANES*8-1:0]      work_r, work_nx_s;
    logic [LANES*8-1:0]             cur_chunk_s;
    logic [LANES*8-1:0]             sub_chunk_s;

    assign cur_chunk_s = work_r[cnt_r];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign sub_chunk_s[l*8 +: 8] = inv_byte(cur_chunk_s[l*8 +: 8]);
    end

    // Next-state, counter and working-register update
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        work_nx_s  = work_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    work_nx_s  = in_state;
                    cnt_nx_s   = '0;
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                work_nx_s[cnt_r] = sub_chunk_s;
                if (cnt_r == CW'(C - 1)) begin
                    cnt_nx_s   = '0;
                    state_nx_s = DONE;
                end else begin
                    cnt_nx_s   = cnt_r + CW'(1);
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = '0;
                work_nx_s  = '0;
            end
        endcase
    end

    // State, counter and working register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            work_r  <= '0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            work_r  <= work_nx_s;
        end
    end

    // Handshakes decode from the state register only, so no ready/valid loop exists
    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r != IDLE);
    assign out_state = work_r;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq at LANES=4, 1 and 16; expected data comes from
// hand constants and a forward S-box built from GF(2^8) arithmetic.
module tb_inv_sub_bytes_seq;

    logic         clk;
    logic         rst_n;
    logic [127:0] in_state;
    logic         out_ready;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic [127:0] out_state [3];
    logic         busy      [3];

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int lat_exp [3] = '{5, 17, 2};

    typedef struct {
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;

    vec_t       vecs [19];
    logic [7:0] sbox_tbl [256];

    inv_sub_bytes_seq #(.LANES(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_state(in_state), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_state(out_state[0]), .busy(busy[0]));

    inv_sub_bytes_seq #(.LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_state(in_state), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_state(out_state[1]), .busy(busy[1]));

    inv_sub_bytes_seq #(.LANES(16)) u_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_state(in_state), .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_state(out_state[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            if (a[7]) a = (a << 1) ^ 8'h1b;
            else      a = a << 1;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] v;
        v = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Send one state to DUT d, measure latency, optionally hold backpressure, then consume.
    task automatic run_vec(input int d, input logic [127:0] st, input logic [127:0] ex,
                           input int hold, input string name);
        int   lat;
        logic rdy_low;
        @(negedge clk);
        in_state    = st;
        in_valid[d] = 1'b1;
        out_ready   = 1'b0;
        check({name, " ready_before"}, 128'(in_ready[d]), 128'd1);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        lat     = 1;
        rdy_low = 1'b1;
        while (!out_valid[d] && lat < 40) begin
            if (in_ready[d]) rdy_low = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (in_ready[d]) rdy_low = 1'b0;
        check({name, " latency"}, 128'(lat), 128'(lat_exp[d]));
        check({name, " in_ready_low"}, 128'(rdy_low), 128'd1);
        check({name, " data"}, out_state[d], ex);
        check({name, " busy"}, 128'(busy[d]), 128'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_state    = ~st;
            in_valid[d] = 1'b1;
            @(posedge clk);
            #1;
            check({name, " bp_valid"}, 128'(out_valid[d]), 128'd1);
            check({name, " bp_data"}, out_state[d], ex);
            check({name, " bp_ready"}, 128'(in_ready[d]), 128'd0);
        end
        @(negedge clk);
        in_valid[d] = 1'b0;
        out_ready   = 1'b1;
        @(posedge clk);
        #1;
        check({name, " consumed_valid"}, 128'(out_valid[d]), 128'd0);
        check({name, " consumed_ready"}, 128'(in_ready[d]), 128'd1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic seen_valid;
        rst_n     = 1'b0;
        in_state  = 128'd0;
        out_ready = 1'b0;
        for (int d = 0; d < 3; d++) in_valid[d] = 1'b0;

        for (int x = 0; x < 256; x++) sbox_tbl[x] = fwd_sbox(8'(x));

        vecs[0].din  = {16{8'h63}};
        vecs[0].dexp = 128'd0;
        vecs[1].din  = {{10{8'h63}}, 8'h16, 8'h52, 8'h00, 8'h01, 8'h7c, 8'h63};
        vecs[1].dexp = {{10{8'h00}}, 8'hff, 8'h48, 8'h52, 8'h09, 8'h01, 8'h00};
        for (int i = 0; i < 16; i++) begin
            vecs[2].din[i*8 +: 8]  = sbox_tbl[i];
            vecs[2].dexp[i*8 +: 8] = 8'(i);
        end
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) begin
                vecs[3+k].din[i*8 +: 8]  = sbox_tbl[16*k + i];
                vecs[3+k].dexp[i*8 +: 8] = 8'(16*k + i);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("reset in_ready", 128'(in_ready[d]), 128'd1);
            check("reset out_valid", 128'(out_valid[d]), 128'd0);
            check("reset out_state", out_state[d], 128'd0);
            check("reset busy", 128'(busy[d]), 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 19; v++) run_vec(0, vecs[v].din, vecs[v].dexp, 0, $sformatf("l4_vec%0d", v));
        for (int d = 1; d < 3; d++) begin
            run_vec(d, vecs[0].din, vecs[0].dexp, 0, $sformatf("sweep%0d_all63", d));
            run_vec(d, vecs[2].din, vecs[2].dexp, 0, $sformatf("sweep%0d_order", d));
        end

        run_vec(0, vecs[2].din, vecs[2].dexp, 6, "backpressure");

        // Reset while LANES=4 instance sits in RUN with cnt=2
        @(negedge clk);
        in_state    = vecs[0].din;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrun busy_before", 128'(busy[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        check("midrun in_ready", 128'(in_ready[0]), 128'd1);
        check("midrun out_valid", 128'(out_valid[0]), 128'd0);
        check("midrun out_state", out_state[0], 128'd0);
        check("midrun busy", 128'(busy[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid[0]) seen_valid = 1'b1;
        end
        check("midrun no_out_valid", 128'(seen_valid), 128'd0);
        run_vec(0, vecs[1].din, vecs[1].dexp, 0, "after_reset");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_seq.md
# inv_sub_bytes_seq

Sequential AES InvSubBytes engine for the decryption datapath. It accepts one 128-bit AES state over a valid/ready handshake and replaces every byte with its inverse S-box value, processing LANES bytes per clock. It returns the result over a second valid/ready handshake. It sits between InvShiftRows and AddRoundKey in the inverse-cipher round, and is the decrypt-side counterpart of the forward byte-substitution table.

## Interface
- LANES, default 4: inverse S-box lookups per cycle. Legal values: 1, 2, 4, 8, 16 (must divide 16). Defines C = 16/LANES.
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  in_state is valid
- in_ready  output  1  block can accept a state
- in_state  input  128  state to substitute; byte i = in_state[8i+7:8i]
- out_valid  output  1  out_state is valid
- out_ready  input  1  downstream accepts out_state
- out_state  output  128  substituted state; same byte mapping as in_state
- busy  output  1  high in RUN or DONE

## Operation
- **Inverse S-box (inv).** inv is the exact inverse of the AES forward S-box: inv(sbox(x)) = x for all 256 x. Anchor values:
  - inv(63)=00, inv(7c)=01, inv(01)=09
  - inv(00)=52, inv(52)=48, inv(16)=ff
- **Instances.** inv is implemented as LANES identical combinational 256-entry lookup instances. No lookup is shared across states.
- **Working register.** One 128-bit register `work` plus a chunk counter `cnt` of width clog2(C), minimum 1 bit.
- **State machine:**
  - IDLE:
    - in_ready=1.
    - On in_valid: work<=in_state, cnt<=0, go to RUN.
  - RUN:
    - Each cycle, bytes cnt*LANES through cnt*LANES+LANES-1 of work are replaced by inv(byte).
    - cnt increments each cycle.
    - After the cycle with cnt=C-1: cnt wraps to 0, go to DONE.
  - DONE:
    - out_valid=1, out_state=work.
    - On out_ready: go to IDLE.
    - Otherwise hold; work and out_state stay stable.
- **Chunk order.** Chunks are processed from the lowest byte index upward. Each byte is transformed exactly once.
- **Output when not valid.** out_state always shows work. Its value is don't-care unless out_valid=1.
- **Handshake signals.** in_ready and out_valid are decoded directly from the state register, with no combinational path from in_valid or out_ready.
- **No overlap.** in_ready=0 in RUN and DONE. in_valid asserted then is ignored, and in_state is not sampled.
- **Reset.** Asynchronous assertion at any time, including mid-RUN or in DONE:
  - state returns to IDLE, cnt=0, work=0;
  - the in-flight state is discarded and no out_valid is produced;
  - after reset: in_ready=1, out_valid=0, out_state=0, busy=0.

## Timing
- **Acceptance.** Acceptance occurs at the edge where in_valid=1 and in_ready=1 (edge A).
- **RUN edges.** RUN occupies edges A+1 through A+C.
- **Output.** out_valid is first high in the cycle after edge A+C.
  - Latency from acceptance: C+1 cycles (LANES=4: 5 cycles; LANES=16: 2 cycles).
- **Consumption.** The result is consumed at the first edge with out_valid=1 and out_ready=1. in_ready rises in the following cycle.
- **Throughput.** With out_ready held high, the minimum spacing between accepted states is C+2 cycles.
- **Backpressure.** Backpressure of any length stretches DONE with no data change.

## Test plan
- **All-63 state.** Reset, then send in_state with all bytes 63 (LANES=4) -> out_state all 00, out_valid high exactly 5 cycles after acceptance, in_ready low throughout.
- **Exhaustive.** Send 16 states whose bytes collectively hold sbox(x) for x=00..ff -> each output byte equals its x. Also check the anchor values above.
- **Byte order.** Send in_state with byte i = sbox(i), i=0..15 -> byte i of out_state = i, confirming byte mapping and chunk order.
- **Backpressure.** Hold out_ready=0 for 6 cycles in DONE -> out_valid stays 1, out_state unchanged, in_valid pulses ignored. Release -> in_ready=1 in the next cycle.
- **Reset mid-RUN.** Drop rst_n during RUN (cnt=2) -> outputs reach reset values immediately. No out_valid appears, and the next state is processed correctly.
- **LANES sweep.** Repeat the all-63 and byte-order cases for LANES=1 and LANES=16 -> latency of 17 and 2 cycles respectively, with results identical.
